// File: rtl/status_reg_pkg.sv
// status_reg_pkg: shared CPU status-register types, SC bit indices and enums.
package status_reg_pkg;
  typedef enum int unsigned {
    FLAG_Z = 0,
    FLAG_C = 1,
    FLAG_V = 2,
    FLAG_S = 3
  } alu_flag_e;
  localparam int unsigned SC_D    = 4;
  localparam int unsigned SC_U    = 5;
  localparam int unsigned SC_I_LO = 6;
  localparam int unsigned SC_I_HI = 7;
  typedef enum logic [3:0] {
    COND_LT    = 4'h0,
    COND_LE    = 4'h1,
    COND_GT    = 4'h2,
    COND_GE    = 4'h3,
    COND_V     = 4'h4,
    COND_NV    = 4'h5,
    COND_P     = 4'h6,
    COND_M     = 4'h7,
    COND_C     = 4'h8,
    COND_NC    = 4'h9,
    COND_Z     = 4'hA,
    COND_NZ    = 4'hB,
    COND_ALWAYS = 4'hC
  } cond_e;
  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_AND  = 2'd1,
    OP_OR   = 2'd2,
    OP_XOR  = 2'd3
  } sc_op_e;
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;
endpackage

// File: rtl/status_reg_cond_eval.sv
// status_reg_cond_eval: combinational branch-condition decoder over the SC flag bits.
module status_reg_cond_eval
  import status_reg_pkg::*;
(
  input  logic [3:0] flags_i,
  input  logic [3:0] cond_i,
  output logic       cond_true_o
);
  logic sv;
  always_comb begin
    sv = flags_i[FLAG_S] ^ flags_i[FLAG_V];
    cond_true_o = 1'b0;
    case (cond_e'(cond_i))
      COND_LT:     cond_true_o = sv;
      COND_LE:     cond_true_o = sv | flags_i[FLAG_Z];
      COND_GT:     cond_true_o = ~(sv | flags_i[FLAG_Z]);
      COND_GE:     cond_true_o = ~sv;
      COND_V:      cond_true_o = flags_i[FLAG_V];
      COND_NV:     cond_true_o = ~flags_i[FLAG_V];
      COND_P:      cond_true_o = ~flags_i[FLAG_S];
      COND_M:      cond_true_o = flags_i[FLAG_S];
      COND_C:      cond_true_o = flags_i[FLAG_C];
      COND_NC:     cond_true_o = ~flags_i[FLAG_C];
      COND_Z:      cond_true_o = flags_i[FLAG_Z];
      COND_NZ:     cond_true_o = ~flags_i[FLAG_Z];
      COND_ALWAYS: cond_true_o = 1'b1;
      default:     cond_true_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/status_reg.sv
// status_reg: SC register with prioritised updates, branch conditions and
// interrupt acceptance at instruction boundaries.
module status_reg
  import status_reg_pkg::*;
#(
  parameter logic [7:0] RESET_SC = 8'hC0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] alu_flags,
  input  logic       flag_we,
  input  logic [3:0] flag_mask,
  input  logic       sc_we,
  input  logic [7:0] sc_in,
  input  logic [1:0] sc_op,
  input  logic       sc_restore,
  input  logic       instr_done,
  input  logic       irq_req,
  input  logic [1:0] irq_level,
  input  logic [3:0] cond,
  output logic [7:0] sc,
  output logic [7:0] sc_saved,
  output logic       cond_true,
  output logic       irq_take
);
  state_e     state_q;
  logic [7:0] sc_q, sc_d, sc_base, op_res, sc_saved_q;
  logic       irq_take_q, accept, sc_change;
  sc_op_e     op;
  assign op = sc_op_e'(sc_op);
  assign sc_change = sc_restore | sc_we | (op != OP_NONE);
  assign accept = (state_q == ST_IDLE) && instr_done && irq_req &&
                  (irq_level > sc_q[SC_I_HI:SC_I_LO]);
  always_comb begin
    op_res  = op == OP_AND ? sc_q & sc_in : op == OP_OR ? sc_q | sc_in : sc_q ^ sc_in;
    sc_base = sc_restore ? sc_saved_q :
              sc_we ? sc_in :
              op != OP_NONE ? op_res :
              flag_we ? {sc_q[7:4], (flag_mask & alu_flags) | (~flag_mask & sc_q[3:0])} :
              sc_q;
    sc_d    = accept ? {irq_level, sc_base[5:0]} : sc_base;
  end
  // An SC write in HOLD re-arms the wait for a fresh instruction boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sc_q       <= RESET_SC;
      sc_saved_q <= 8'h00;
      irq_take_q <= 1'b0;
    end else begin
      state_q    <= (accept || sc_change) ? ST_HOLD :
                    (state_q == ST_HOLD && !instr_done) ? ST_HOLD : ST_IDLE;
      sc_q       <= sc_d;
      irq_take_q <= accept;
      if (accept) sc_saved_q <= sc_q;
    end
  end
  status_reg_cond_eval u_cond (
    .flags_i    (sc_q[3:0]),
    .cond_i     (cond),
    .cond_true_o(cond_true)
  );
  assign sc       = sc_q;
  assign sc_saved = sc_saved_q;
  assign irq_take = irq_take_q;
endmodule
